// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALU codes and mux selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBeq,
        StJal,
        StTrap
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] ResultAluReg   = 2'b00;
    localparam logic [1:0] ResultReadData = 2'b01;
    localparam logic [1:0] ResultAluOut   = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath-facing signal bundle of the multicycle controller.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct_3;
    logic [6:0] funct_7;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal;

    // Datapath side: drives instruction fields and status, receives controls.
    modport master (
        output opcode, funct_3, funct_7, zero, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, result_src, alu_src_a, alu_src_b,
        input  alu_ctrl, imm_src, reg_write, illegal
    );

    // Controller side.
    modport slave (
        input  opcode, funct_3, funct_7, zero, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, result_src, alu_src_a, alu_src_b,
        output alu_ctrl, imm_src, reg_write, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's coarse ALU request and instruction funct fields onto an alu_ctrl code.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct_3,
    input  logic       funct_7_5,
    input  logic       opcode_5,
    output logic [2:0] alu_ctrl
);

    // Funct decode; only R-type (opcode[5]=1) with funct_7[5] selects subtract.
    always_comb begin
        alu_ctrl = AluAdd;
        case (alu_op)
            AluOpSub:   alu_ctrl = AluSub;
            AluOpFunct: begin
                case (funct_3)
                    3'b000:  alu_ctrl = (opcode_5 & funct_7_5) ? AluSub : AluAdd;
                    3'b010:  alu_ctrl = AluSlt;
                    3'b110:  alu_ctrl = AluOr;
                    3'b111:  alu_ctrl = AluAnd;
                    default: alu_ctrl = AluAdd;
                endcase
            end
            default:    alu_ctrl = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: Moore-decoded datapath controls with memory handshakes.
module multicycle_controller
    import multicycle_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    multicycle_controller_if.slave bus
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl;
    logic       unused_funct_7;

    assign unused_funct_7 = ^{bus.funct_7[6], bus.funct_7[4:0]};

    // State register; reset drops straight back to fetch, even mid-wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mem_ready only matters in the three waiting states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIType:         state_d = StExecuteI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr:   state_d = (bus.opcode == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  if (bus.mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (bus.mem_ready) state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
    end

    // Per-state control decode; fetch enables are gated off while reset is held.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.result_src = ResultAluReg;
        bus.alu_src_a  = SrcAPc;
        bus.alu_src_b  = SrcBRs2;
        bus.reg_write  = 1'b0;
        bus.illegal    = 1'b0;
        alu_op         = AluOpAdd;
        unique case (state_q)
            StFetch: begin
                bus.pc_write   = bus.mem_ready & rst_n;
                bus.ir_write   = bus.mem_ready & rst_n;
                bus.result_src = ResultAluOut;
                bus.alu_src_a  = SrcAPc;
                bus.alu_src_b  = SrcBFour;
            end
            StDecode: begin
                bus.alu_src_a = SrcAOldPc;
                bus.alu_src_b = SrcBImm;
            end
            StMemAdr: begin
                bus.alu_src_a = SrcARs1;
                bus.alu_src_b = SrcBImm;
            end
            StMemRead: begin
                bus.adr_src = 1'b1;
            end
            StMemWb: begin
                bus.result_src = ResultReadData;
                bus.reg_write  = 1'b1;
            end
            StMemWrite: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            StExecuteR: begin
                bus.alu_src_a = SrcARs1;
                bus.alu_src_b = SrcBRs2;
                alu_op        = AluOpFunct;
            end
            StExecuteI: begin
                bus.alu_src_a = SrcARs1;
                bus.alu_src_b = SrcBImm;
                alu_op        = AluOpFunct;
            end
            StAluWb: begin
                bus.reg_write = 1'b1;
            end
            StBeq: begin
                bus.alu_src_a = SrcARs1;
                bus.alu_src_b = SrcBRs2;
                bus.pc_write  = bus.zero;
                alu_op        = AluOpSub;
            end
            StJal: begin
                bus.alu_src_a = SrcAOldPc;
                bus.alu_src_b = SrcBFour;
                bus.pc_write  = 1'b1;
            end
            StTrap: begin
                bus.illegal = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        case (bus.opcode)
            OpStore: bus.imm_src = ImmS;
            OpBeq:   bus.imm_src = ImmB;
            OpJal:   bus.imm_src = ImmJ;
            default: bus.imm_src = ImmI;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op    (alu_op),
        .funct_3   (bus.funct_3),
        .funct_7_5 (bus.funct_7[5]),
        .opcode_5  (bus.opcode[5]),
        .alu_ctrl  (alu_ctrl)
    );

    assign bus.alu_ctrl = alu_ctrl;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle vector table through a scoreboard queue, plus a store-stall sequence.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef enum {SFetch, SDecode, SMemAdr, SMemRead, SMemWb, SMemWrite,
                  SExR, SExI, SAluWb, SBeq, SJal, STrap} st_e;

    typedef struct {
        string      nm;
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        logic       mr;
        logic [16:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t        vecs[$];
    logic [16:0] sb_exp[$];
    string       sb_nm[$];
    int          total = 0;
    int          bad = 0;

    // ALU decode cases: opcode, funct_3, funct_7, expected alu_ctrl.
    logic [6:0] alu_op_t[8] = '{RT, IT, RT, RT, IT, RT, IT, RT};
    logic [2:0] alu_f3_t[8] = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b111, 3'b010, 3'b100, 3'b001};
    logic [6:0] alu_f7_t[8] = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
    logic [2:0] alu_ex_t[8] = '{3'b001, 3'b000, 3'b000, 3'b011, 3'b010, 3'b101, 3'b000, 3'b000};

    // Expected output word {pc_write, adr_src, ir_write, mem_write, result_src, alu_src_a,
    // alu_src_b, alu_ctrl, imm_src, reg_write, illegal} for a state, written from the spec table.
    function automatic logic [16:0] ex(st_e st, logic pcw, logic irw, logic [2:0] ctrl,
                                       logic [1:0] imm);
        logic       pw, ad, iw, mw, rw, il;
        logic [1:0] rs, a, b;
        logic [2:0] c;
        pw = 0; ad = 0; iw = 0; mw = 0; rw = 0; il = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; c = 3'b000;
        case (st)
            SFetch:    begin pw = pcw; iw = irw; rs = 2'b10; b = 2'b10; end
            SDecode:   begin a = 2'b01; b = 2'b01; end
            SMemAdr:   begin a = 2'b10; b = 2'b01; end
            SMemRead:  ad = 1;
            SMemWb:    begin rs = 2'b01; rw = 1; end
            SMemWrite: begin ad = 1; mw = 1; end
            SExR:      begin a = 2'b10; c = ctrl; end
            SExI:      begin a = 2'b10; b = 2'b01; c = ctrl; end
            SAluWb:    rw = 1;
            SBeq:      begin a = 2'b10; c = 3'b001; pw = pcw; end
            SJal:      begin a = 2'b01; b = 2'b10; pw = 1; end
            STrap:     il = 1;
            default:   ;
        endcase
        return {pw, ad, iw, mw, rs, a, b, c, imm, rw, il};
    endfunction

    function automatic void add_vec(string nm, logic rst, logic [6:0] op, logic [2:0] f3,
                                    logic [6:0] f7, logic z, logic mr, logic [16:0] e);
        vec_t v;
        v.nm = nm; v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic logic [16:0] actual();
        return {bus.pc_write, bus.adr_src, bus.ir_write, bus.mem_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.imm_src, bus.reg_write,
                bus.illegal};
    endfunction

    task automatic check(input string nm, input logic [16:0] e);
        logic [16:0] a;
        a = actual();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, a, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wcnt;
        bit done;

        rst_n = 1'b0;
        bus.opcode = LW; bus.funct_3 = 3'b000; bus.funct_7 = 7'h00;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;

        // Reset: fetch decode with fetch enables forced off.
        add_vec("rst0", 0, LW, 0, 0, 0, 1, ex(SFetch, 0, 0, 0, 2'b00));
        add_vec("rst1", 0, SW, 0, 0, 0, 1, ex(SFetch, 0, 0, 0, 2'b01));
        // lw, mem_ready high throughout.
        add_vec("lw_f",   1, LW, 0, 0, 0, 1, ex(SFetch, 1, 1, 0, 2'b00));
        add_vec("lw_d",   1, LW, 0, 0, 0, 1, ex(SDecode, 0, 0, 0, 2'b00));
        add_vec("lw_adr", 1, LW, 0, 0, 0, 1, ex(SMemAdr, 0, 0, 0, 2'b00));
        add_vec("lw_rd",  1, LW, 0, 0, 0, 1, ex(SMemRead, 0, 0, 0, 2'b00));
        add_vec("lw_wb",  1, LW, 0, 0, 0, 1, ex(SMemWb, 0, 0, 0, 2'b00));
        // sw with three stalled write cycles.
        add_vec("sw_f",   1, SW, 0, 0, 0, 1, ex(SFetch, 1, 1, 0, 2'b01));
        add_vec("sw_d",   1, SW, 0, 0, 0, 0, ex(SDecode, 0, 0, 0, 2'b01));
        add_vec("sw_adr", 1, SW, 0, 0, 0, 1, ex(SMemAdr, 0, 0, 0, 2'b01));
        for (int i = 0; i < 3; i++) add_vec("sw_wait", 1, SW, 0, 0, 0, 0,
                                            ex(SMemWrite, 0, 0, 0, 2'b01));
        add_vec("sw_done", 1, SW, 0, 0, 0, 1, ex(SMemWrite, 0, 0, 0, 2'b01));
        add_vec("f_stall", 1, RT, 0, 0, 0, 0, ex(SFetch, 0, 0, 0, 2'b00));
        // ALU-type instructions through execute and writeback.
        for (int i = 0; i < 8; i++) begin
            add_vec("alu_f",  1, alu_op_t[i], alu_f3_t[i], alu_f7_t[i], 0, 1,
                    ex(SFetch, 1, 1, 0, 2'b00));
            add_vec("alu_d",  1, alu_op_t[i], alu_f3_t[i], alu_f7_t[i], 0, 1,
                    ex(SDecode, 0, 0, 0, 2'b00));
            add_vec("alu_ex", 1, alu_op_t[i], alu_f3_t[i], alu_f7_t[i], 0, 1,
                    ex((alu_op_t[i] == RT) ? SExR : SExI, 0, 0, alu_ex_t[i], 2'b00));
            add_vec("alu_wb", 1, alu_op_t[i], alu_f3_t[i], alu_f7_t[i], 0, 1,
                    ex(SAluWb, 0, 0, 0, 2'b00));
        end
        // beq taken and not taken.
        add_vec("beq1_f", 1, BQ, 0, 0, 0, 1, ex(SFetch, 1, 1, 0, 2'b10));
        add_vec("beq1_d", 1, BQ, 0, 0, 1, 1, ex(SDecode, 0, 0, 0, 2'b10));
        add_vec("beq1_b", 1, BQ, 0, 0, 1, 0, ex(SBeq, 1, 0, 0, 2'b10));
        add_vec("beq0_f", 1, BQ, 0, 0, 1, 1, ex(SFetch, 1, 1, 0, 2'b10));
        add_vec("beq0_d", 1, BQ, 0, 0, 1, 1, ex(SDecode, 0, 0, 0, 2'b10));
        add_vec("beq0_b", 1, BQ, 0, 0, 0, 1, ex(SBeq, 0, 0, 0, 2'b10));
        // jal.
        add_vec("jal_f",  1, JL, 0, 0, 0, 1, ex(SFetch, 1, 1, 0, 2'b11));
        add_vec("jal_d",  1, JL, 0, 0, 0, 1, ex(SDecode, 0, 0, 0, 2'b11));
        add_vec("jal_j",  1, JL, 0, 0, 0, 1, ex(SJal, 1, 0, 0, 2'b11));
        add_vec("jal_wb", 1, JL, 0, 0, 0, 1, ex(SAluWb, 0, 0, 0, 2'b11));
        // lw interrupted by reset while waiting in MEM_READ.
        add_vec("lwr_f",   1, LW, 0, 0, 0, 1, ex(SFetch, 1, 1, 0, 2'b00));
        add_vec("lwr_d",   1, LW, 0, 0, 0, 0, ex(SDecode, 0, 0, 0, 2'b00));
        add_vec("lwr_adr", 1, LW, 0, 0, 0, 0, ex(SMemAdr, 0, 0, 0, 2'b00));
        add_vec("lwr_rd0", 1, LW, 0, 0, 0, 0, ex(SMemRead, 0, 0, 0, 2'b00));
        add_vec("lwr_rd1", 1, LW, 0, 0, 0, 0, ex(SMemRead, 0, 0, 0, 2'b00));
        add_vec("lwr_rst", 0, LW, 0, 0, 0, 0, ex(SFetch, 0, 0, 0, 2'b00));
        add_vec("lwr_rel", 1, LW, 0, 0, 0, 0, ex(SFetch, 0, 0, 0, 2'b00));
        // Illegal opcode: trap absorbs for 10 cycles, then reset clears it.
        add_vec("bad_f", 1, BAD, 0, 0, 0, 1, ex(SFetch, 1, 1, 0, 2'b00));
        add_vec("bad_d", 1, BAD, 0, 0, 0, 1, ex(SDecode, 0, 0, 0, 2'b00));
        for (int i = 0; i < 10; i++) add_vec("trap", 1, (i % 2 == 0) ? BAD : LW, 0, 0, 1,
                                             1, ex(STrap, 0, 0, 0, 2'b00));
        add_vec("trap_rst", 0, LW, 0, 0, 0, 1, ex(SFetch, 0, 0, 0, 2'b00));
        add_vec("trap_rel", 1, LW, 0, 0, 0, 1, ex(SFetch, 1, 1, 0, 2'b00));

        // Apply one vector per cycle; expectation is queued on drive, popped on sampling.
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst_n         = vecs[i].rst;
            bus.opcode    = vecs[i].op;
            bus.funct_3   = vecs[i].f3;
            bus.funct_7   = vecs[i].f7;
            bus.zero      = vecs[i].z;
            bus.mem_ready = vecs[i].mr;
            sb_exp.push_back(vecs[i].exp);
            sb_nm.push_back(vecs[i].nm);
            @(negedge clk);
            check(sb_nm.pop_front(), sb_exp.pop_front());
        end

        // Store with mem_ready low for the first three write cycles: mem_write must span four.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.opcode = SW; bus.mem_ready = 1'b1;
        wcnt = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk); #1;
            if (bus.mem_write) begin
                wcnt++;
                bus.mem_ready = (wcnt >= 4);
                done = (wcnt >= 4);
            end else begin
                bus.mem_ready = 1'b1;
            end
        end
        total++;
        if (wcnt != 4) begin
            bad++;
            $display("FAIL sw_stall_len: got %0d cycles want 4", wcnt);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("sw_stall_ret", ex(SFetch, 1, 1, 0, 2'b01));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The interface SHALL have these parameters and default-less fixed constants: none; all encodings come from the shared package (REQ-025).
REQ-002 The ports SHALL be exactly as follows:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  opcode  in  7  instruction opcode from IR
  funct_3  in  3  instruction funct3 from IR
  funct_7  in  7  instruction funct7 from IR
  zero  in  1  ALU zero flag
  mem_ready  in  1  memory access complete this cycle
  pc_write  out  1  PC register load enable
  adr_src  out  1  memory address select: 0 PC, 1 ALU result register
  ir_write  out  1  instruction/old-PC register load enable
  mem_write  out  1  memory write strobe
  result_src  out  2  result mux: 00 ALU result reg, 01 read data, 10 ALU output
  alu_src_a  out  2  ALU A select: 00 PC, 01 old PC, 10 rs1 register
  alu_src_b  out  2  ALU B select: 00 rs2 register, 01 immediate, 10 constant 4
  alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
  imm_src  out  2  00 I, 01 S, 10 B, 11 J
  reg_write  out  1  register file write enable
  illegal  out  1  sticky illegal-opcode flag
REQ-003 One clock; reset is asynchronous and active-low.

Function
REQ-004 States SHALL be FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE_R, EXECUTE_I, ALU_WB, BEQ, JAL, TRAP.
REQ-005 Outputs SHALL be Moore-decoded from the current state, except pc_write, ir_write and imm_src, which also depend on inputs as stated below; unlisted outputs SHALL be 0.
REQ-006 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10; pc_write=ir_write=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-007 DECODE: alu_src_a=01, alu_src_b=01, add. Next state by opcode: 0000011/0100011 to MEM_ADR, 0110011 to EXECUTE_R, 0010011 to EXECUTE_I, 1100011 to BEQ, 1101111 to JAL, any other opcode to TRAP.
REQ-008 MEM_ADR: alu_src_a=10, alu_src_b=01, add. Go to MEM_READ for opcode 0000011, else MEM_WRITE.
REQ-009 MEM_READ: adr_src=1, result_src=00. Stay while mem_ready=0, else go to MEM_WB.
REQ-010 MEM_WB: result_src=01, reg_write=1. Go to FETCH.
REQ-011 MEM_WRITE: adr_src=1, result_src=00, mem_write=1 held every cycle until mem_ready=1. Then go to FETCH.
REQ-012 EXECUTE_R: alu_src_a=10, alu_src_b=00, funct-decoded ALU op. Go to ALU_WB.
REQ-013 EXECUTE_I: alu_src_a=10, alu_src_b=01, funct-decoded ALU op. Go to ALU_WB.
REQ-014 ALU_WB: result_src=00, reg_write=1. Go to FETCH.
REQ-015 BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero. Go to FETCH.
REQ-016 JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Go to ALU_WB.
REQ-017 TRAP: illegal=1 and all write enables 0. TRAP is absorbing until reset.
REQ-018 The funct-decoded ALU op SHALL map funct_3 as follows: 000 gives sub if opcode[5]&funct_7[5] else add; 010 gives slt; 110 gives or; 111 gives and; any other value gives add.
REQ-019 imm_src SHALL be combinational from opcode: 0100011 gives 01, 1100011 gives 10, 1101111 gives 11, all others 00.
REQ-020 Decoding SHALL use opcode/funct values as presented in the current cycle; the IR is held stable by ir_write=0 outside FETCH.
REQ-021 A mem_ready pulse outside FETCH, MEM_READ or MEM_WRITE SHALL be ignored.

Reset
REQ-022 Asserting rst_n low SHALL force state FETCH immediately, in any state including mid-wait, and clear illegal.
REQ-023 While in reset, outputs SHALL equal the FETCH decode with mem_ready as given; pc_write and ir_write SHALL be forced to 0.
REQ-024 The first FETCH after deassertion SHALL begin on the first rising edge with rst_n high.

Structure
REQ-025 A package multicycle_pkg SHALL hold the state enum, opcode constants, alu_ctrl codes, and the result_src/alu_src_a/alu_src_b encodings.
REQ-026 The funct-to-alu_ctrl decode SHALL be a sub-module alu_decoder with inputs alu_op[1:0] (00 add, 01 sub, 10 funct), funct_3, funct_7[5] and opcode[5].
REQ-027 The state register SHALL be the only sequential element.

Verification
REQ-028 lw with mem_ready=1 throughout SHALL visit FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, FETCH in 5 cycles, with reg_write=1 and result_src=01 only in cycle 5.
REQ-029 sw with mem_ready low for 3 cycles in MEM_WRITE SHALL hold mem_write=1 for 4 cycles, then return to FETCH.
REQ-030 R-type sub (funct_3=000, funct_7=0100000) SHALL produce alu_ctrl=001 in EXECUTE_R; addi with funct_7[5]=1 SHALL produce 000.
REQ-031 beq with zero=1 SHALL give pc_write=1 in BEQ, and with zero=0 SHALL give pc_write=0; jal SHALL give pc_write=1 in JAL, then reg_write=1 in ALU_WB.
REQ-032 opcode 1111111 SHALL lead to TRAP with illegal=1 and no writes for 10 cycles; asserting rst_n low mid-MEM_READ wait SHALL return to FETCH with illegal=0.
